// File: rtl/iopad_bank_sched.sv
// Half-duplex scheduler for a bank of bidirectional iopads sharing one pad bus.
// Arbitrates TX/RX requesters, bounds bursts under contention and inserts turnaround cycles.
module iopad_bank_sched #(
  parameter int WIDTH       = 8,
  parameter int TURN_CYCLES = 2,
  parameter int MAX_BURST   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_req,
  input  logic [WIDTH-1:0] tx_data,
  output logic             tx_ack,
  input  logic             rx_req,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic [WIDTH-1:0] pad_din,
  output logic [WIDTH-1:0] pad_dout,
  output logic             pad_direction,
  output logic             pad_zin
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    TURN_TO_TX = 3'd1,
    TX         = 3'd2,
    TURN_TO_RX = 3'd3,
    RX         = 3'd4
  } state_t;

  localparam logic [3:0] TURN_LOAD  = 4'(TURN_CYCLES - 1);
  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);
  localparam logic       GRANT_RX   = 1'b0;
  localparam logic       GRANT_TX   = 1'b1;

  state_t     state;
  logic [3:0] turn_cnt;
  logic [7:0] burst_cnt;
  logic       last_grant;

  // Pad controls decode straight from the registered state so the bus never glitches.
  assign pad_direction = !(state == TURN_TO_TX || state == TX);
  assign pad_zin       = (state != TX);
  assign pad_dout      = (state == TX) ? tx_data : '0;
  assign tx_ack        = (state == TX) && tx_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      turn_cnt   <= 4'd0;
      burst_cnt  <= 8'd0;
      last_grant <= GRANT_RX;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (state == RX && rx_req) begin
        rx_data  <= pad_din;
        rx_valid <= 1'b1;
      end

      case (state)
        IDLE: begin
          // On a tie the side that did not hold the bus last gets it.
          if (tx_req && (!rx_req || last_grant == GRANT_RX)) begin
            state    <= TURN_TO_TX;
            turn_cnt <= TURN_LOAD;
          end else if (rx_req) begin
            state      <= RX;
            last_grant <= GRANT_RX;
            burst_cnt  <= 8'd0;
          end
        end

        TURN_TO_TX: begin
          if (turn_cnt == 4'd0) begin
            if (tx_req) begin
              state      <= TX;
              last_grant <= GRANT_TX;
              burst_cnt  <= 8'd0;
            end else begin
              state    <= TURN_TO_RX;
              turn_cnt <= TURN_LOAD;
            end
          end else begin
            turn_cnt <= turn_cnt - 4'd1;
          end
        end

        TX: begin
          if (!tx_req) begin
            state    <= TURN_TO_RX;
            turn_cnt <= TURN_LOAD;
          end else if (burst_cnt == BURST_LAST) begin
            burst_cnt <= 8'd0;
            if (rx_req) begin
              state    <= TURN_TO_RX;
              turn_cnt <= TURN_LOAD;
            end
          end else begin
            burst_cnt <= burst_cnt + 8'd1;
          end
        end

        TURN_TO_RX: begin
          if (turn_cnt == 4'd0) begin
            if (rx_req) begin
              state      <= RX;
              last_grant <= GRANT_RX;
              burst_cnt  <= 8'd0;
            end else begin
              state <= IDLE;
            end
          end else begin
            turn_cnt <= turn_cnt - 4'd1;
          end
        end

        RX: begin
          if (!rx_req) begin
            if (tx_req) begin
              state    <= TURN_TO_TX;
              turn_cnt <= TURN_LOAD;
            end else begin
              state <= IDLE;
            end
          end else if (burst_cnt == BURST_LAST) begin
            burst_cnt <= 8'd0;
            if (tx_req) begin
              state    <= TURN_TO_TX;
              turn_cnt <= TURN_LOAD;
            end
          end else begin
            burst_cnt <= burst_cnt + 8'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
